// File: rtl/wb_boot_copier_pkg.sv
// Shared types and constants for the Wishbone boot-image copier.
package wb_boot_copier_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RD_GAP,
    WR,
    WR_GAP,
    DONE,
    FAIL
  } state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [3:0] SEL_ALL     = 4'hF;

  localparam int IDX_W = 16;
  localparam int TMO_W = 16;

  // Byte address of word idx in a region; wraps modulo 2^32.
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [IDX_W-1:0] idx);
    return base + {14'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/wb_boot_copier_wdog.sv
// Bus-phase watchdog: loadable down-counter that flags expiry on the last
// enabled cycle of the loaded budget.
module wb_boot_copier_wdog
  import wb_boot_copier_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [TMO_W-1:0] load_value,
  input  logic             clear,
  input  logic             enable,
  output logic             expired
);

  logic [TMO_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (enable && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  // The count equals the number of waiting cycles still allowed, including this one.
  assign expired = enable && (count_reg == TMO_W'(1));

endmodule

// File: rtl/wb_boot_copier.sv
// Wishbone classic master that copies WORDS words from SRC_BASE to DST_BASE
// while holding the CPU in reset. Optional checksum: BOOT_COPY_CHECKSUM_EN.
module wb_boot_copier
  import wb_boot_copier_pkg::*;
#(
  parameter logic [31:0] SRC_BASE = 32'hF000_0000,
  parameter logic [31:0] DST_BASE = 32'h0000_0000,
  parameter int unsigned WORDS    = 1024,
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] EXP_SUM  = 32'h0
) (
  input  logic        wb_clk,
  input  logic        wb_rst_n,
  input  logic        start_i,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic [2:0]  wbm_cti_o,
  output logic [1:0]  wbm_bte_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
`ifdef BOOT_COPY_CHECKSUM_EN
  output logic [31:0] checksum_o,
`endif
  output logic        cpu_rst_o,
  output logic        done_o,
  output logic        err_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT);

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [31:0]      adr_reg, adr_next;
  logic [31:0]      dat_reg, dat_next;
  logic             cyc_reg, cyc_next;
  logic             we_reg, we_next;
  logic             done_reg, err_reg, cpu_rst_reg;
  logic             phase_reg, phase_next;
  logic             tmo_expired, tmo_enable, tmo_load, tmo_clear;
  logic             last_ok;

`ifdef BOOT_COPY_CHECKSUM_EN
  logic [31:0] sum_reg, sum_next;
  assign last_ok    = (sum_reg == EXP_SUM);
  assign checksum_o = sum_reg;

  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) sum_reg <= '0;
    else           sum_reg <= sum_next;
  end
`else
  logic unused_exp_sum;
  assign unused_exp_sum = ^EXP_SUM;
  assign last_ok        = 1'b1;
`endif

  assign phase_reg  = (state_reg == RD) || (state_reg == WR);
  assign phase_next = (state_next == RD) || (state_next == WR);
  assign tmo_enable = phase_reg && !wbm_ack_i && !wbm_err_i;
  assign tmo_load   = phase_next && (state_next != state_reg);
  assign tmo_clear  = phase_reg && !phase_next;

  wb_boot_copier_wdog u_wdog (
    .clk        (wb_clk),
    .rst_n      (wb_rst_n),
    .load       (tmo_load),
    .load_value (TMO_LOAD),
    .clear      (tmo_clear),
    .enable     (tmo_enable),
    .expired    (tmo_expired)
  );

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    adr_next   = adr_reg;
    dat_next   = dat_reg;
    cyc_next   = 1'b0;
    we_next    = 1'b0;
`ifdef BOOT_COPY_CHECKSUM_EN
    sum_next   = sum_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (start_i) begin
          state_next = RD;
          cyc_next   = 1'b1;
          adr_next   = word_addr(SRC_BASE, idx_reg);
        end
      end
      RD: begin
        cyc_next = 1'b1;
        // err has priority over a simultaneous ack.
        if (wbm_err_i || tmo_expired) begin
          state_next = FAIL;
          cyc_next   = 1'b0;
        end else if (wbm_ack_i) begin
          state_next = RD_GAP;
          cyc_next   = 1'b0;
          dat_next   = wbm_dat_i;
`ifdef BOOT_COPY_CHECKSUM_EN
          sum_next   = sum_reg + wbm_dat_i;
`endif
        end
      end
      RD_GAP: begin
        state_next = WR;
        cyc_next   = 1'b1;
        we_next    = 1'b1;
        adr_next   = word_addr(DST_BASE, idx_reg);
      end
      WR: begin
        cyc_next = 1'b1;
        we_next  = 1'b1;
        if (wbm_err_i || tmo_expired) begin
          state_next = FAIL;
          cyc_next   = 1'b0;
          we_next    = 1'b0;
        end else if (wbm_ack_i) begin
          cyc_next = 1'b0;
          we_next  = 1'b0;
          if (idx_reg == LAST_IDX) state_next = last_ok ? DONE : FAIL;
          else                     state_next = WR_GAP;
        end
      end
      WR_GAP: begin
        idx_next   = idx_reg + 1'b1;
        state_next = RD;
        cyc_next   = 1'b1;
        adr_next   = word_addr(SRC_BASE, idx_next);
      end
      DONE, FAIL: begin
        state_next = state_reg;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) begin
      state_reg   <= IDLE;
      idx_reg     <= '0;
      adr_reg     <= '0;
      dat_reg     <= '0;
      cyc_reg     <= 1'b0;
      we_reg      <= 1'b0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
      cpu_rst_reg <= 1'b1;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      adr_reg     <= adr_next;
      dat_reg     <= dat_next;
      cyc_reg     <= cyc_next;
      we_reg      <= we_next;
      done_reg    <= (state_next == DONE);
      err_reg     <= (state_next == FAIL);
      cpu_rst_reg <= (state_next != DONE);
    end
  end

  assign wbm_adr_o = adr_reg;
  assign wbm_dat_o = dat_reg;
  assign wbm_sel_o = SEL_ALL;
  assign wbm_we_o  = we_reg;
  assign wbm_cyc_o = cyc_reg;
  assign wbm_stb_o = cyc_reg;
  assign wbm_cti_o = CTI_CLASSIC;
  assign wbm_bte_o = BTE_LINEAR;
  assign cpu_rst_o = cpu_rst_reg;
  assign done_o    = done_reg;
  assign err_o     = err_reg;

endmodule

// File: tb/tb_wb_boot_copier.sv
// Scoreboarded bench for wb_boot_copier: random ROM images and slave latency,
// injected bus errors, write timeout, mid-copy reset and source address wrap.
`timescale 1ns/1ps
module tb_wb_boot_copier;

  localparam logic [31:0] SRC    = 32'hFFFF_FFF0;
  localparam logic [31:0] DST    = 32'h0000_0100;
  localparam int          W      = 8;
  localparam int          TMO    = 8;
  localparam logic [31:0] SUM_OK = 32'd36;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] adr, dat_o;
  logic [31:0] dat_i = '0;
  logic [3:0]  sel;
  logic        we, cyc, stb;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack = 1'b0;
  logic        berr = 1'b0;
  logic        cpu_rst, done, fail_flag;
`ifdef BOOT_COPY_CHECKSUM_EN
  logic [31:0] csum;
  logic [31:0] exp_sum;
`endif

  always #5 clk = ~clk;

  wb_boot_copier #(
    .SRC_BASE (SRC),
    .DST_BASE (DST),
    .WORDS    (W),
    .TIMEOUT  (TMO),
    .EXP_SUM  (SUM_OK)
  ) u_dut (
    .wb_clk     (clk),
    .wb_rst_n   (rst_n),
    .start_i    (start),
    .wbm_adr_o  (adr),
    .wbm_dat_o  (dat_o),
    .wbm_sel_o  (sel),
    .wbm_we_o   (we),
    .wbm_cyc_o  (cyc),
    .wbm_stb_o  (stb),
    .wbm_cti_o  (cti),
    .wbm_bte_o  (bte),
    .wbm_dat_i  (dat_i),
    .wbm_ack_i  (ack),
    .wbm_err_i  (berr),
`ifdef BOOT_COPY_CHECKSUM_EN
    .checksum_o (csum),
`endif
    .cpu_rst_o  (cpu_rst),
    .done_o     (done),
    .err_o      (fail_flag)
  );

  // ---------------- slave model (ROM + RAM in one sparse memory) ----------
  logic [31:0] mem [logic [31:0]];
  int          lat_max  = 0;
  int          lat_cur  = 0;
  int          wait_cnt = 0;
  logic        err_arm  = 1'b0;
  logic [31:0] err_adr  = '0;
  logic        hang_wr  = 1'b0;

  always @(posedge clk) begin
    if (!(cyc && stb) || ack || berr) begin
      ack      <= 1'b0;
      berr     <= 1'b0;
      wait_cnt <= 0;
    end else if (wait_cnt >= lat_cur) begin
      if (err_arm && !we && adr == err_adr) begin
        berr <= 1'b1;
      end else if (!(hang_wr && we)) begin
        ack <= 1'b1;
        if (we) mem[adr] = dat_o;
        else    dat_i <= mem.exists(adr) ? mem[adr] : 32'hDEAD_BEEF;
      end
      lat_cur <= $urandom_range(lat_max, 0);
    end else begin
      wait_cnt <= wait_cnt + 1;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
  } wr_t;

  wr_t         exp_wr_q[$];
  logic [31:0] exp_rd_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          wr_seen = 0;
  int          stb_wr_cycles = 0;
  logic [31:0] rom_words [W];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Monitor: every completed bus phase is compared against the queued expectation.
  always @(negedge clk) begin
    wr_t e;
    if (cyc && stb && we) stb_wr_cycles++;
    if (cyc && stb && (ack || berr)) begin
      $display("%s adr=%h dat=%h ack=%b err=%b", we ? "WR" : "RD", adr, we ? dat_o : dat_i, ack, berr);
      if (we) begin
        wr_seen++;
        if (exp_wr_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL wr_unexpected: got adr %h dat %h, required no write", adr, dat_o);
        end else begin
          e = exp_wr_q.pop_front();
          check("wr_adr", adr, e.adr);
          check("wr_dat", dat_o, e.dat);
        end
      end else begin
        check("rd_sel", 32'(sel), 32'h0000_000F);
        check("rd_cti_bte", 32'({cti, bte}), 32'h0);
        if (exp_rd_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rd_unexpected: got adr %h, required no read", adr);
        end else begin
          check("rd_adr", adr, exp_rd_q.pop_front());
        end
      end
    end
  end

  // ---------------- reference model ----------------
  task automatic load_rom(input bit counting);
    for (int i = 0; i < W; i++) begin
      rom_words[i] = counting ? 32'(i + 1) : $urandom;
      mem[SRC + 32'(4 * i)] = rom_words[i];
      if (mem.exists(DST + 32'(4 * i))) mem.delete(DST + 32'(4 * i));
    end
  endtask

  // Copies word by word until the injected error/hang point, then decides the outcome.
  task automatic expect_run(input int err_rd, input int hang_idx, output bit exp_done);
    logic [31:0] sum;
    wr_t         e;
    bit          stop;
    sum = '0;
    stop = 1'b0;
    exp_done = 1'b1;
    exp_wr_q.delete();
    exp_rd_q.delete();
    for (int i = 0; i < W && !stop; i++) begin
      exp_rd_q.push_back(SRC + 32'(4 * i));
      if (i == err_rd) begin
        stop = 1'b1;
      end else begin
        sum += rom_words[i];
        if (i == hang_idx) begin
          stop = 1'b1;
        end else begin
          e.adr = DST + 32'(4 * i);
          e.dat = rom_words[i];
          exp_wr_q.push_back(e);
        end
      end
    end
    if (stop) exp_done = 1'b0;
`ifdef BOOT_COPY_CHECKSUM_EN
    else exp_done = (sum == SUM_OK);
    exp_sum = sum;
`endif
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run(input string tag, input int lmax, input int err_rd, input bit hang,
                     input bit counting, input bit chk_cycles, input bit mid_rst);
    bit exp_done;
    int cyc_cnt;
    int mism;
    $display("run %s", tag);
    lat_max = lmax;
    err_arm = (err_rd >= 0);
    err_adr = SRC + 32'(4 * err_rd);
    hang_wr = hang;
    reset_dut();
    check("rst_cyc", 32'(cyc), 32'h0);
    check("rst_adr", adr, 32'h0);
    check("rst_cpu_rst", 32'(cpu_rst), 32'h1);
    check("rst_done_err", 32'({done, fail_flag}), 32'h0);
    load_rom(counting);
    expect_run(err_rd, hang ? 0 : -1, exp_done);
    wr_seen = 0;
    stb_wr_cycles = 0;
    start = 1'b1;
    cyc_cnt = 0;
    if (mid_rst) begin
      while (!(wr_seen == 2 && cyc && we) && cyc_cnt < 2000) begin
        @(negedge clk);
        cyc_cnt++;
      end
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_cyc_stb", 32'({cyc, stb}), 32'h0);
      check("midrst_cpu_rst", 32'(cpu_rst), 32'h1);
      rst_n = 1'b1;
      start = 1'b1;
      expect_run(err_rd, -1, exp_done);
      cyc_cnt = 0;
    end
    while (!(done || fail_flag) && cyc_cnt < 2000) begin
      @(negedge clk);
      cyc_cnt++;
      if (cyc_cnt == 2) start = 1'b0;
    end
    if (cyc_cnt >= 2000) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got no done/err within 2000 cycles, required completion", tag);
    end
    if (chk_cycles) check("cycles", 32'(cyc_cnt), 32'(6 * W));
    check("done", 32'(done), 32'(exp_done));
    check("err", 32'(fail_flag), 32'(!exp_done));
    check("cpu_rst", 32'(cpu_rst), 32'(!exp_done));
    check("wr_q_left", 32'(exp_wr_q.size()), 32'h0);
    check("rd_q_left", 32'(exp_rd_q.size()), 32'h0);
`ifdef BOOT_COPY_CHECKSUM_EN
    check("checksum", csum, exp_sum);
`endif
    if (hang) check("tmo_stb_cycles", 32'(stb_wr_cycles), 32'(TMO));
    if (err_rd >= 0) check("rd_err_writes", 32'(wr_seen), 32'(err_rd));
    if (err_rd < 0 && !hang) begin
      mism = 0;
      for (int i = 0; i < W; i++)
        if (!mem.exists(DST + 32'(4 * i)) || mem[DST + 32'(4 * i)] !== rom_words[i]) mism++;
      check("dst_mem_mismatches", 32'(mism), 32'h0);
    end
    // Terminal states are sticky and ignore start.
    start = 1'b1;
    repeat (3) @(negedge clk);
    check("sticky_cyc", 32'(cyc), 32'h0);
    check("sticky_done_err", 32'({done, fail_flag}), 32'({exp_done, !exp_done}));
    start = 1'b0;
  endtask

  initial begin
    run("basic_1cyc", 0, -1, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int r = 0; r < 3; r++) run("rand_lat", 5, -1, 1'b0, 1'b0, 1'b0, 1'b0);
    run("rd_err_2nd", 0, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    run("wr_timeout", 2, -1, 1'b1, 1'b0, 1'b0, 1'b0);
    run("mid_reset", 0, -1, 1'b0, 1'b0, 1'b1, 1'b1);
    run("rand_sum_ok", 3, -1, 1'b0, 1'b1, 1'b0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_boot_copier.md
Name: wb_boot_copier

Overview:
- Wishbone B3 classic-cycle master (initiator) that copies a boot image of WORDS 32-bit words from a source region (boot ROM) to a destination region (RAM).
- Holds the CPU in reset while copying and releases it on success.
- Sits beside the CPU as an extra master port on the Wishbone intercon, driven by the same slaves the CPU uses.

Parameters:
- SRC_BASE, 32'hF000_0000, byte address of first source word (word aligned)
- DST_BASE, 32'h0000_0000, byte address of first destination word (word aligned)
- WORDS, 1024, number of 32-bit words to copy; legal range 1..65535
- TIMEOUT, 255, max cycles waiting for ack/err in one phase before abort; legal range 1..65535
- EXP_SUM, 32'h0, expected checksum; used only with BOOT_COPY_CHECKSUM_EN

Ports:
- wb_clk  in  1  system clock
- wb_rst_n  in  1  synchronous, active-low reset
- start_i  in  1  level; copy starts when high in IDLE
- wbm_adr_o  out  32  address
- wbm_dat_o  out  32  write data
- wbm_sel_o  out  4  byte select, always 4'hF
- wbm_we_o  out  1  write enable
- wbm_cyc_o  out  1  cycle
- wbm_stb_o  out  1  strobe
- wbm_cti_o  out  3  always 3'b000 (classic)
- wbm_bte_o  out  2  always 2'b00
- wbm_dat_i  in  32  read data
- wbm_ack_i  in  1  acknowledge
- wbm_err_i  in  1  error
- cpu_rst_o  out  1  CPU reset request, active high
- done_o  out  1  copy completed successfully
- err_o  out  1  copy aborted (bus error, timeout, or checksum mismatch)
- checksum_o  out  32  running checksum (present only with BOOT_COPY_CHECKSUM_EN)

Behaviour:
- All outputs registered.
- Reset values:
  - cyc, stb, we, done_o, err_o = 0
  - adr, dat, checksum_o = 0
  - cpu_rst_o = 1
  - idx = 0
  - state = IDLE
- States: IDLE, RD, RD_GAP, WR, WR_GAP, DONE, FAIL.
- IDLE: cyc/stb low. When start_i=1, go to RD next cycle with cyc=stb=1, we=0, adr=SRC_BASE+4*idx.
- RD: hold all outputs until ack or err is sampled.
  - ack: latch wbm_dat_i into data register; drop cyc/stb next cycle; go to RD_GAP.
  - err: go to FAIL.
- RD_GAP: one idle cycle. Then WR with cyc=stb=we=1, adr=DST_BASE+4*idx, dat=latched word.
- WR: hold all outputs until ack or err is sampled.
  - ack: drop cyc/stb/we; go to WR_GAP. If idx==WORDS-1, go to DONE instead.
  - err: go to FAIL.
- WR_GAP: idx increments; next cycle enters RD.
- Throughput: min 6 cycles per word with single-cycle-latency slaves (ack one cycle after stb rises).
- Priority: ack and err in the same cycle → err wins.
- Timeout: a watchdog counts cycles in RD/WR while stb=1 without ack/err. Count reaching TIMEOUT → FAIL. Counter clears on every phase entry.
- DONE: cpu_rst_o=0, done_o=1. Sticky until reset; start_i ignored.
- FAIL: err_o=1, cpu_rst_o stays 1, bus idle. Sticky until reset.
- Address arithmetic: 32-bit, wraps modulo 2^32. idx is 16 bits.
- start_i falling mid-copy: no effect; the copy always runs to completion.
- Reset mid-transfer: cyc/stb drop in the same edge and state returns to IDLE. The slave-side transaction is abandoned.

Optional Feature:
- Macro BOOT_COPY_CHECKSUM_EN.
- Defined:
  - Each word latched in RD is added, modulo 2^32, to checksum_o.
  - On the final write ack, the sum including the last word is compared to EXP_SUM. Mismatch → FAIL instead of DONE.
  - checksum_o port exists.
- Undefined:
  - No adder, no checksum_o port.
  - Final write ack always → DONE.

Decomposition:
- Package wb_boot_copier_pkg:
  - state enum
  - CTI_CLASSIC=3'b000, BTE_LINEAR=2'b00, SEL_ALL=4'hF
  - width constants: IDX_W=16, TMO_W=16
- One sub-module, wb_boot_copier_wdog: loadable down-counter with clear, enable and expired outputs.
- FSM, address generation and checksum stay in the top.

Test Plan:
- WORDS=4, SRC=0xF000_0000, ROM words 0x11,0x22,0x33,0x44, 1-cycle ack slave, start_i=1 → writes 0x11..0x44 to 0x0,0x4,0x8,0xC; done_o=1 and cpu_rst_o=0 on the cycle after the 4th write ack; 24 cycles total.
- Slave asserts err on the 2nd read (adr 0xF000_0004) → err_o=1, cpu_rst_o=1, exactly one write issued, cyc=0 afterwards.
- TIMEOUT=8, slave never acks the first write → FAIL entered after 8 cycles with stb high; err_o=1.
- BOOT_COPY_CHECKSUM_EN, words 1,2,3,4, EXP_SUM=10 → done_o=1, checksum_o=10; rerun with EXP_SUM=11 → err_o=1, done_o=0.
- wb_rst_n pulled low while the 3rd write is in WR → cyc/stb=0 the next cycle, cpu_rst_o=1; after release and start_i, the copy restarts at idx 0.
- Random 0-5 cycle ack latency, WORDS=64, address wrap SRC=0xFFFF_FFF0 → destination contents match and the source address wraps to 0x0000_0000 after 4 words.
